// File: rtl/serial_sum_deserializer.sv
// Rebuilds a parallel sum word and carry-out from an LSB-first bit-serial frame,
// with a one-word valid/ready output buffer and abort/overrun error pulses.
module serial_sum_deserializer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_start,
    input  logic             s_bit,
    output logic [WIDTH-1:0] p_sum,
    output logic             p_cout,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             err_abort,
    output logic             err_overrun
);

    // state | meaning
    // IDLE  | waiting for s_start, stray bits ignored
    // SHIFT | frame partially received, r_cnt = next bit index
    typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LP_LAST = CW'(WIDTH);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_sh, w_sh_nxt;
    logic [WIDTH-1:0] r_p_sum;
    logic             r_p_cout, r_p_valid, r_err_abort, r_err_overrun;
    logic             w_done, w_abort, w_load, w_overrun, w_p_valid_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh_nxt    = r_sh;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_valid && s_start) begin
                    w_sh_nxt    = {{(WIDTH-1){1'b0}}, s_bit};
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (s_valid) begin
                    if (s_start) begin
                        // Restart: partial frame is discarded, this bit is bit 0 again
                        w_abort   = 1'b1;
                        w_sh_nxt  = {{(WIDTH-1){1'b0}}, s_bit};
                        w_cnt_nxt = CW'(1);
                    end else if (r_cnt < LP_LAST) begin
                        w_sh_nxt[r_cnt] = s_bit;
                        w_cnt_nxt       = r_cnt + 1'b1;
                    end else begin
                        w_done      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A same-cycle accept frees the buffer for the completing frame
        w_load        = w_done && (!r_p_valid || p_ready);
        w_overrun     = w_done && r_p_valid && !p_ready;
        w_p_valid_nxt = r_p_valid;
        if (w_load)
            w_p_valid_nxt = 1'b1;
        else if (r_p_valid && p_ready)
            w_p_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_sh          <= '0;
            r_p_sum       <= '0;
            r_p_cout      <= 1'b0;
            r_p_valid     <= 1'b0;
            r_err_abort   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_sh          <= w_sh_nxt;
            r_p_valid     <= w_p_valid_nxt;
            r_err_abort   <= w_abort;
            r_err_overrun <= w_overrun;
            if (w_load) begin
                r_p_sum  <= r_sh;
                r_p_cout <= s_bit;
            end
        end
    end

    assign p_sum       = r_p_sum;
    assign p_cout      = r_p_cout;
    assign p_valid     = r_p_valid;
    assign busy        = (r_state == ST_SHIFT);
    assign err_abort   = r_err_abort;
    assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Randomized bench for serial_sum_deserializer against a frame-level queue model.
module tb_serial_sum_deserializer;

    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_start = 1'b0;
    logic             s_bit = 1'b0;
    logic             p_ready = 1'b0;
    logic [WIDTH-1:0] p_sum;
    logic             p_cout, p_valid, busy, err_abort, err_overrun;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          m_bits[$];
    bit          m_in_frame;
    int unsigned m_sum;
    bit          m_cout, m_valid, m_abort, m_overrun;

    serial_sum_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_start    (s_start),
        .s_bit      (s_bit),
        .p_sum      (p_sum),
        .p_cout     (p_cout),
        .p_valid    (p_valid),
        .p_ready    (p_ready),
        .busy       (busy),
        .err_abort  (err_abort),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits     = {};
        m_in_frame = 0;
        m_sum      = 0;
        m_cout     = 0;
        m_valid    = 0;
        m_abort    = 0;
        m_overrun  = 0;
    endtask

    // One clock edge of behaviour, expressed on whole frames
    task automatic model_edge(input bit v, input bit s, input bit b, input bit r);
        bit done = 0;
        bit acc  = m_valid && r;
        m_abort   = 0;
        m_overrun = 0;
        if (v) begin
            if (s) begin
                if (m_in_frame) m_abort = 1;
                m_bits     = {b};
                m_in_frame = 1;
            end else if (m_in_frame) begin
                m_bits.push_back(b);
                if (m_bits.size() == WIDTH + 1) begin
                    done       = 1;
                    m_in_frame = 0;
                end
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                m_sum = 0;
                for (int k = 0; k < WIDTH; k++) m_sum += m_bits[k] * (1 << k);
                m_cout  = m_bits[WIDTH][0];
                m_valid = 1;
            end else begin
                m_overrun = 1;
            end
        end else if (acc) begin
            m_valid = 0;
        end
    endtask

    task automatic check_all();
        check("p_valid", p_valid, m_valid);
        check("busy", busy, m_in_frame);
        check("err_abort", err_abort, m_abort);
        check("err_overrun", err_overrun, m_overrun);
        check("p_sum", p_sum, m_sum);
        check("p_cout", p_cout, m_cout);
    endtask

    task automatic step(input bit v, input bit s, input bit b, input bit r);
        @(negedge clk);
        s_valid = v;
        s_start = s;
        s_bit   = b;
        p_ready = r;
        @(posedge clk);
        model_edge(v, s, b, r);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_start = 1'b0;
        p_ready = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] sum, input bit c, input int gap_pct,
                              input bit rdy, input bit rdy_last);
        logic [WIDTH-1:0] w;
        w = sum;
        for (int i = 0; i <= WIDTH; i++) begin
            if (i > 0 && int'($urandom_range(99)) < gap_pct) step(0, 0, 1'($urandom), rdy);
            if (i < WIDTH) step(1, i == 0, w[i], rdy);
            else           step(1, 0, c, rdy_last);
        end
    endtask

    initial begin
        #2;
        do_reset();

        // basic frame: sum 33, carry 0
        send_frame(6'b100001, 1'b0, 0, 1'b1, 1'b1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // all-zero sum with carry, gaps, late ready
        send_frame(6'b000000, 1'b1, 50, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // back-to-back overrun, then same-cycle accept and load
        send_frame(6'b111111, 1'b0, 0, 1'b0, 1'b0);
        send_frame(6'b000001, 1'b1, 0, 1'b0, 1'b0);
        step(0, 0, 0, 0);
        send_frame(6'b000001, 1'b1, 0, 1'b0, 1'b1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // abort after 3 bits, then a full frame
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        send_frame(6'b010101, 1'b0, 0, 1'b0, 1'b0);
        step(0, 0, 0, 1);

        // stray bits in IDLE
        for (int i = 0; i < 6; i++) step(1, 0, 1'($urandom), 0);

        // reset mid-frame, then with a held result
        step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        do_reset();
        send_frame(6'b101101, 1'b1, 0, 1'b0, 1'b0);
        do_reset();
        send_frame(6'b011010, 1'b0, 20, 1'b0, 1'b0);
        step(0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit v, s;
            v = ($urandom_range(99) < 75);
            s = v && ($urandom_range(99) < 12);
            step(v, s, 1'($urandom), $urandom_range(99) < 50);
            if (i == 700) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
